// File: rtl/mix_pkg.sv
// Shared types and constants for the iterative 8-lane mixing datapath.
// The lane tables below are the per-lane multipliers and addends of the two multiply stages.
package mix_pkg;

    localparam int NLANES = 8;

    typedef logic [31:0] lane_t;
    typedef lane_t [NLANES-1:0] state_t;

    typedef enum logic [2:0] {
        S0, S1, S2, S3, S4, S5, S6, S7
    } stage_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    localparam lane_t MIX_A [NLANES] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
    localparam lane_t MIX_B [NLANES] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
    localparam lane_t MIX_C [NLANES] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
    localparam lane_t MIX_D [NLANES] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

    // Neighbour lane index, wrapping around the eight lanes.
    function automatic logic [2:0] lane_idx(input int base, input int off);
        lane_idx = 3'((base + off) & 7);
    endfunction

endpackage

// File: rtl/mix_stage.sv
// One mix stage, purely combinational. Lanes are updated in order 0..7 and
// each lane sees the already-updated lower lanes of the same stage.
module mix_stage
    import mix_pkg::*;
(
    input  stage_t stage_i,
    input  state_t lanes_i,
    output state_t lanes_o
);

    state_t o;

    always_comb begin
        o = lanes_i;
        // Updating o in place is what creates the in-order dependency chain.
        for (int i = 0; i < NLANES; i++) begin
            case (stage_i)
                S0: o[i] = o[i] + lane_t'(i);
                S1: o[i] = o[i] + o[lane_idx(i, 7)];
                S2: o[i] = o[i] + o[lane_idx(i, 1)] - o[lane_idx(i, 5)];
                S3: o[i] = o[i] ^ (o[lane_idx(i, 3)] << 16);
                S4: o[i] = o[i] - (o[lane_idx(i, 2)] >> 17) + (o[lane_idx(i, 4)] >> 12);
                S5: o[i] = o[i] + o[lane_idx(i, 7)] - o[lane_idx(i, 6)];
                S6: o[i] = o[i] * MIX_A[i] + MIX_B[i];
                S7: o[i] = o[i] * MIX_C[i] + MIX_D[i];
                default: o[i] = o[i];
            endcase
        end
        lanes_o = o;
    end

endmodule

// File: rtl/mix_round_sequencer.sv
// Iterative mix controller: accepts a seed, runs one stage per clock for
// n_rounds full rounds, then holds the result until the consumer takes it.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a job
//   RUN   | applying one mix stage per clock
//   DONE  | result held with out_valid until out_ready or abort
module mix_round_sequencer
    import mix_pkg::*;
#(
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [255:0]  seed_i,
    input  logic [RW-1:0] n_rounds,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [255:0]  result_o,
    output logic          busy,
    output logic [RW-1:0] round_o
);

    fsm_t          fsm_q, fsm_d;
    state_t        lanes_q, lanes_d;
    stage_t        stage_q, stage_d;
    logic [RW-1:0] round_q, round_d;
    logic [RW-1:0] nr_q, nr_d;
    state_t        stage_out;

    mix_stage u_stage (
        .stage_i (stage_q),
        .lanes_i (lanes_q),
        .lanes_o (stage_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            lanes_q <= '0;
            stage_q <= S0;
            round_q <= '0;
            nr_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            lanes_q <= lanes_d;
            stage_q <= stage_d;
            round_q <= round_d;
            nr_q    <= nr_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        lanes_d = lanes_q;
        stage_d = stage_q;
        round_d = round_q;
        nr_d    = nr_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    lanes_d = seed_i;
                    nr_d    = n_rounds;
                    stage_d = S0;
                    round_d = '0;
                    // A zero-round job goes straight to DONE and returns the seed.
                    fsm_d   = (n_rounds != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    fsm_d   = IDLE;
                    stage_d = S0;
                    round_d = '0;
                end else begin
                    lanes_d = stage_out;
                    stage_d = stage_t'(stage_q + 3'd1);
                    if (stage_q == S7) begin
                        round_d = round_q + RW'(1);
                        if ((round_q + RW'(1)) == nr_q) begin
                            fsm_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    fsm_d   = IDLE;
                    round_d = '0;
                end else if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q == RUN);
    assign out_valid = (fsm_q == DONE);
    assign result_o  = lanes_q;
    assign round_o   = round_q;

endmodule
